// File: rtl/fab_bram_pkg.sv
// rtl/fab_bram_pkg.sv - shared constants and types for the fabric BRAM responder
package fab_bram_pkg;
    localparam int ADDR_W = 8;
    localparam int DEPTH  = 256;

    typedef enum logic [1:0] {
        W32  = 2'b00,
        W16  = 2'b01,
        W8   = 2'b10,
        WRSV = 2'b11
    } width_e;

    localparam int CFG_WIDTH  = 0;
    localparam int CFG_LANE   = 2;
    localparam int CFG_WE     = 4;
    localparam int CFG_WFIRST = 5;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } state_e;
endpackage

// File: rtl/fab_bram_lane.sv
// rtl/fab_bram_lane.sv - lane merge for writes and lane extraction for reads
module fab_bram_lane
    import fab_bram_pkg::*;
(
    input  width_e      i_width,
    input  logic [1:0]  i_lane,
    input  logic [31:0] i_old_word,
    input  logic [31:0] i_wr_data,
    input  logic [31:0] i_rd_word,
    output logic [31:0] o_merged,
    output logic [31:0] o_rd_ext
);

    always_comb begin
        o_merged = i_wr_data;
        o_rd_ext = i_rd_word;
        case (i_width)
            W16: begin
                // Only the low lane bit picks the halfword in 16-bit mode.
                if (i_lane[0]) begin
                    o_merged = {i_wr_data[15:0], i_old_word[15:0]};
                    o_rd_ext = {16'h0, i_rd_word[31:16]};
                end else begin
                    o_merged = {i_old_word[31:16], i_wr_data[15:0]};
                    o_rd_ext = {16'h0, i_rd_word[15:0]};
                end
            end
            W8: begin
                case (i_lane)
                    2'd0: begin
                        o_merged = {i_old_word[31:8], i_wr_data[7:0]};
                        o_rd_ext = {24'h0, i_rd_word[7:0]};
                    end
                    2'd1: begin
                        o_merged = {i_old_word[31:16], i_wr_data[7:0], i_old_word[7:0]};
                        o_rd_ext = {24'h0, i_rd_word[15:8]};
                    end
                    2'd2: begin
                        o_merged = {i_old_word[31:24], i_wr_data[7:0], i_old_word[15:0]};
                        o_rd_ext = {24'h0, i_rd_word[23:16]};
                    end
                    default: begin
                        o_merged = {i_wr_data[7:0], i_old_word[23:0]};
                        o_rd_ext = {24'h0, i_rd_word[31:24]};
                    end
                endcase
            end
            default: begin
                o_merged = i_wr_data;
                o_rd_ext = i_rd_word;
            end
        endcase
    end

endmodule

// File: rtl/fab_bram_model.sv
// rtl/fab_bram_model.sv - 256x32 BRAM tile port responder with zero-fill sequencer
module fab_bram_model #(
    parameter int DEPTH  = fab_bram_pkg::DEPTH,
    parameter int ADDR_W = fab_bram_pkg::ADDR_W
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic [ADDR_W-1:0] i_rd_addr,
    input  logic [ADDR_W-1:0] i_wr_addr,
    input  logic [31:0]       i_wr_data,
    input  logic [7:0]        i_config,
    output logic [31:0]       o_rd_data,
    output logic              o_init_done
);
    import fab_bram_pkg::*;

    logic [31:0]       r_mem [DEPTH];
    state_e            r_state;
    state_e            w_state_nxt;
    logic [ADDR_W-1:0] r_sweep;
    logic [31:0]       r_rd_data;
    logic              r_init_done;

    width_e            w_width;
    logic [1:0]        w_lane;
    logic              w_we;
    logic              w_wfirst;
    logic [31:0]       w_old_word;
    logic [31:0]       w_rd_word;
    logic [31:0]       w_merged;
    logic [31:0]       w_rd_ext;
    logic              w_sweep_last;
    logic              w_mem_we;
    logic [ADDR_W-1:0] w_mem_addr;
    logic [31:0]       w_mem_din;
    logic              w_unused;

    assign w_width      = width_e'(i_config[CFG_WIDTH +: 2]);
    assign w_lane       = i_config[CFG_LANE +: 2];
    assign w_we         = i_config[CFG_WE];
    assign w_wfirst     = i_config[CFG_WFIRST];
    assign w_unused     = &{1'b0, i_config[7:6]};
    assign w_sweep_last = (r_sweep == ADDR_W'(DEPTH - 1));

    assign w_old_word = r_mem[i_wr_addr];
    // Write-first on a colliding address reads the merged word before it lands.
    assign w_rd_word  = (w_we && w_wfirst && (i_rd_addr == i_wr_addr)) ? w_merged
                                                                      : r_mem[i_rd_addr];

    fab_bram_lane u_lane (
        .i_width    (w_width),
        .i_lane     (w_lane),
        .i_old_word (w_old_word),
        .i_wr_data  (i_wr_data),
        .i_rd_word  (w_rd_word),
        .o_merged   (w_merged),
        .o_rd_ext   (w_rd_ext)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_mem_we    = 1'b0;
        w_mem_addr  = i_wr_addr;
        w_mem_din   = w_merged;
        case (r_state)
            INIT: begin
                w_mem_we   = 1'b1;
                w_mem_addr = r_sweep;
                w_mem_din  = 32'h0;
                if (w_sweep_last) begin
                    w_state_nxt = RUN;
                end
            end
            default: begin
                w_mem_we = w_we;
            end
        endcase
    end

    // The array has no reset; an edge seen while reset is low must not write.
    always_ff @(posedge i_clk) begin
        if (i_rst_n && w_mem_we) begin
            r_mem[w_mem_addr] <= w_mem_din;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= INIT;
            r_sweep     <= '0;
            r_rd_data   <= 32'h0;
            r_init_done <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == INIT) begin
                r_sweep   <= r_sweep + 1'b1;
                r_rd_data <= 32'h0;
                if (w_sweep_last) begin
                    r_init_done <= 1'b1;
                end
            end else begin
                r_rd_data <= w_rd_ext;
            end
        end
    end

    assign o_rd_data   = r_rd_data;
    assign o_init_done = r_init_done;

endmodule
